// File: rtl/host_wr_queue.sv
// Coalescing line-writeback queue drained to the host write bus; host_wgo rises two cycles after a push into an idle empty queue.
// Backpressure: the head is held while host_wr_ready=0, and wr_full refuses new non-coalescing pushes.
module host_wr_queue #(
   parameter int DEPTH  = 4,
   parameter int LINE_W = 512,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_init,
   input  logic              wr_req,
   input  logic [31:0]       wr_addr,
   input  logic [LINE_W-1:0] wr_data,
   output logic              wr_full,
   output logic              wr_empty,
   input  logic [31:0]       chk_addr,
   output logic              chk_hazard,
   input  logic              host_wr_ready,
   output logic              host_wgo,
   output logic              host_we,
   output logic [63:0]       cpu_addr,
   output logic [LINE_W-1:0] host_data_bus_write_out
);
   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [PW:0]       count_q, count_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [LINE_W-1:0] data_d [DEPTH];

   logic [DEPTH-1:0]  wr_hit, chk_hit;
   logic              pop, coalesce, push_new;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{wr_addr[31:ADDR_W], chk_addr[31:ADDR_W]};

   // The head being drained is still visible to the hazard check but never coalesced into.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         chk_hit[i] = vld_q[i] && (addr_q[i] == chk_addr[ADDR_W-1:0]);
         wr_hit[i]  = vld_q[i] && (addr_q[i] == wr_addr[ADDR_W-1:0])
                      && !((state_q == ST_DRAIN) && (head_q == PW'(i)));
      end
   end

   assign pop        = (state_q == ST_DRAIN) && host_wr_ready;
   assign coalesce   = wr_req && (|wr_hit);
   assign push_new   = wr_req && !coalesce && (count_q != FULL_CNT);
   assign wr_full    = (count_q == FULL_CNT);
   assign wr_empty   = (count_q == '0);
   assign chk_hazard = |chk_hit;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + (PW+1)'(push_new) - (PW+1)'(pop);
      vld_d   = vld_q;
      addr_d  = addr_q;
      data_d  = data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (coalesce && wr_hit[i]) data_d[i] = wr_data;
      end
      if (push_new) begin
         addr_d[tail_q] = wr_addr[ADDR_W-1:0];
         data_d[tail_q] = wr_data;
         vld_d[tail_q]  = 1'b1;
         tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end
   end

   always_comb begin
      state_d                 = state_q;
      host_wgo                = 1'b0;
      host_we                 = 1'b0;
      cpu_addr                = '0;
      host_data_bus_write_out = '0;
      case (state_q)
         ST_STARTUP: if (host_init) state_d = ST_IDLE;
         ST_IDLE:    if (count_q != '0) state_d = ST_DRAIN;
         ST_DRAIN: begin
            host_wgo                = 1'b1;
            cpu_addr                = {{(62-ADDR_W){1'b0}}, addr_q[head_q], 2'b00};
            host_data_bus_write_out = data_q[head_q];
            if (host_wr_ready) begin
               host_we = 1'b1;
               state_d = (count_q > (PW+1)'(1)) ? ST_DRAIN : ST_IDLE;
            end
         end
         default:    state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= ST_STARTUP;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Payload is qualified by vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_host_wr_queue.sv
// Directed table-driven bench for host_wr_queue plus a hand-written async-reset/startup sequence.
module tb_host_wr_queue;
   logic         clk, rst_n, host_init, wr_req, host_wr_ready;
   logic [31:0]  wr_addr, chk_addr;
   logic [511:0] wr_data, host_data_bus_write_out;
   logic         wr_full, wr_empty, chk_hazard, host_wgo, host_we;
   logic [63:0]  cpu_addr;

   int nerr = 0;
   int nchk = 0;

   host_wr_queue #(.DEPTH(4), .LINE_W(512), .ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .host_init(host_init),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_full(wr_full), .wr_empty(wr_empty),
      .chk_addr(chk_addr), .chk_hazard(chk_hazard),
      .host_wr_ready(host_wr_ready), .host_wgo(host_wgo), .host_we(host_we),
      .cpu_addr(cpu_addr), .host_data_bus_write_out(host_data_bus_write_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [7:0]  tag;
      logic        init;
      logic        rdy;
      logic [31:0] chk;
      logic        wgo;
      logic        we;
      logic [63:0] cpu;
      logic        full;
      logic        empty;
      logic        haz;
      logic [7:0]  dtag;
   } vec_t;

   localparam int NV = 30;
   vec_t vt [NV];

   function automatic logic [511:0] dat(input logic [7:0] t);
      logic [511:0] d;
      d = (t == 8'h00) ? '0 : {16{24'hD0C0DE, t}};
      return d;
   endfunction

   function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic [7:0] tag,
                               input logic init, input logic rdy, input logic [31:0] chk,
                               input logic wgo, input logic we, input logic [63:0] cpu,
                               input logic full, input logic empty, input logic haz,
                               input logic [7:0] dtag);
      vec_t v;
      v.req = req; v.addr = addr; v.tag = tag; v.init = init; v.rdy = rdy; v.chk = chk;
      v.wgo = wgo; v.we = we; v.cpu = cpu; v.full = full; v.empty = empty; v.haz = haz;
      v.dtag = dtag;
      return v;
   endfunction

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [7:0] t);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = dat(t);
   endtask

   initial begin
      int   waited;
      logic found;

      //            req addr      tag    ini rdy chk          wgo we cpu     ful emp haz dtag
      // startup gating, then single drain
      vt[0]  = mk(1, 32'h10,    8'h01, 0, 0, 32'h0,      0, 0, 64'h0,  0, 1, 0, 8'h00);
      vt[1]  = mk(0, 32'h0,     8'h00, 0, 0, 32'h10,     0, 0, 64'h0,  0, 0, 1, 8'h00);
      vt[2]  = mk(0, 32'h0,     8'h00, 0, 0, 32'h10,     0, 0, 64'h0,  0, 0, 1, 8'h00);
      vt[3]  = mk(0, 32'h0,     8'h00, 1, 0, 32'h10,     0, 0, 64'h0,  0, 0, 1, 8'h00);
      vt[4]  = mk(0, 32'h0,     8'h00, 1, 0, 32'h10,     0, 0, 64'h0,  0, 0, 1, 8'h00);
      vt[5]  = mk(0, 32'h0,     8'h00, 1, 0, 32'h10,     1, 0, 64'h40, 0, 0, 1, 8'h01);
      vt[6]  = mk(0, 32'h0,     8'h00, 1, 1, 32'h10,     1, 1, 64'h40, 0, 0, 1, 8'h01);
      vt[7]  = mk(0, 32'h0,     8'h00, 1, 0, 32'h10,     0, 0, 64'h0,  0, 1, 0, 8'h00);
      // fill under backpressure, dropped push on full+pop, in-order drain
      vt[8]  = mk(1, 32'h1,     8'h11, 1, 0, 32'h0,      0, 0, 64'h0,  0, 1, 0, 8'h00);
      vt[9]  = mk(1, 32'h2,     8'h12, 1, 0, 32'h0,      0, 0, 64'h0,  0, 0, 0, 8'h00);
      vt[10] = mk(1, 32'h3,     8'h13, 1, 0, 32'h0,      1, 0, 64'h4,  0, 0, 0, 8'h11);
      vt[11] = mk(1, 32'h4,     8'h14, 1, 0, 32'h0,      1, 0, 64'h4,  0, 0, 0, 8'h11);
      vt[12] = mk(0, 32'h0,     8'h00, 1, 0, 32'h0,      1, 0, 64'h4,  1, 0, 0, 8'h11);
      vt[13] = mk(1, 32'h9,     8'h19, 1, 1, 32'h0,      1, 1, 64'h4,  1, 0, 0, 8'h11);
      vt[14] = mk(0, 32'h0,     8'h00, 1, 1, 32'h9,      1, 1, 64'h8,  0, 0, 0, 8'h12);
      vt[15] = mk(0, 32'h0,     8'h00, 1, 1, 32'h9,      1, 1, 64'hC,  0, 0, 0, 8'h13);
      vt[16] = mk(0, 32'h0,     8'h00, 1, 1, 32'h9,      1, 1, 64'h10, 0, 0, 0, 8'h14);
      vt[17] = mk(0, 32'h0,     8'h00, 1, 1, 32'h9,      0, 0, 64'h0,  0, 1, 0, 8'h00);
      // coalesce into non-head, head-in-flight match becomes new entry, hazard tracking
      vt[18] = mk(1, 32'h5,     8'h25, 1, 0, 32'h0,      0, 0, 64'h0,  0, 1, 0, 8'h00);
      vt[19] = mk(1, 32'h6,     8'h26, 1, 0, 32'h0,      0, 0, 64'h0,  0, 0, 0, 8'h00);
      vt[20] = mk(0, 32'h0,     8'h00, 1, 0, 32'h6,      1, 0, 64'h14, 0, 0, 1, 8'h25);
      vt[21] = mk(1, 32'h6,     8'h36, 1, 0, 32'h6,      1, 0, 64'h14, 0, 0, 1, 8'h25);
      vt[22] = mk(1, 32'h5,     8'h35, 1, 0, 32'h0,      1, 0, 64'h14, 0, 0, 0, 8'h25);
      vt[23] = mk(1, 32'h7,     8'h37, 1, 0, 32'h0,      1, 0, 64'h14, 0, 0, 0, 8'h25);
      vt[24] = mk(0, 32'h0,     8'h00, 1, 0, 32'h7,      1, 0, 64'h14, 1, 0, 1, 8'h25);
      vt[25] = mk(0, 32'h0,     8'h00, 1, 1, 32'h10007,  1, 1, 64'h14, 1, 0, 1, 8'h25);
      vt[26] = mk(0, 32'h0,     8'h00, 1, 1, 32'h7,      1, 1, 64'h18, 0, 0, 1, 8'h36);
      vt[27] = mk(0, 32'h0,     8'h00, 1, 1, 32'h7,      1, 1, 64'h14, 0, 0, 1, 8'h35);
      vt[28] = mk(0, 32'h0,     8'h00, 1, 1, 32'h7,      1, 1, 64'h1C, 0, 0, 1, 8'h37);
      vt[29] = mk(0, 32'h0,     8'h00, 1, 0, 32'h7,      0, 0, 64'h0,  0, 1, 0, 8'h00);

      rst_n = 1'b0; host_init = 1'b0; wr_req = 1'b0; host_wr_ready = 1'b0;
      wr_addr = '0; chk_addr = '0; wr_data = '0;
      #1 rst_n = 1'b1;
      #1;
      check("rst_wgo", host_wgo, 1'b0);
      check("rst_we", host_we, 1'b0);
      check("rst_full", wr_full, 1'b0);
      check("rst_empty", wr_empty, 1'b1);
      check("rst_haz", chk_hazard, 1'b0);
      check("rst_cpu", cpu_addr, 64'h0);
      check("rst_data", host_data_bus_write_out, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;

      for (int i = 0; i < NV; i++) begin
         wr_req = vt[i].req; wr_addr = vt[i].addr; wr_data = dat(vt[i].tag);
         host_init = vt[i].init; host_wr_ready = vt[i].rdy; chk_addr = vt[i].chk;
         #1;
         check($sformatf("r%0d_wgo", i), host_wgo, vt[i].wgo);
         check($sformatf("r%0d_we", i), host_we, vt[i].we);
         check($sformatf("r%0d_cpu", i), cpu_addr, vt[i].cpu);
         check($sformatf("r%0d_full", i), wr_full, vt[i].full);
         check($sformatf("r%0d_empty", i), wr_empty, vt[i].empty);
         check($sformatf("r%0d_haz", i), chk_hazard, vt[i].haz);
         check($sformatf("r%0d_data", i), host_data_bus_write_out, dat(vt[i].dtag));
         @(negedge clk);
      end

      // async reset while draining three entries
      host_wr_ready = 1'b0;
      push(32'hA, 8'h2A);
      @(negedge clk) push(32'hB, 8'h2B);
      @(negedge clk) push(32'hC, 8'h2C);
      @(negedge clk) wr_req = 1'b0;
      chk_addr = 32'hA;
      #1;
      check("ar_pre_wgo", host_wgo, 1'b1);
      check("ar_pre_cpu", cpu_addr, 64'h28);
      check("ar_pre_full", wr_full, 1'b0);
      check("ar_pre_haz", chk_hazard, 1'b1);
      #2 rst_n = 1'b1;
      #1;
      check("ar_wgo", host_wgo, 1'b0);
      check("ar_we", host_we, 1'b0);
      check("ar_empty", wr_empty, 1'b1);
      check("ar_cpu", cpu_addr, 64'h0);
      check("ar_haz", chk_hazard, 1'b0);
      host_wr_ready = 1'b1;
      host_init = 1'b0;
      @(negedge clk) #1;
      check("ar_hold_we", host_we, 1'b0);
      check("ar_hold_wgo", host_wgo, 1'b0);
      check("ar_hold_empty", wr_empty, 1'b1);
      rst_n = 1'b0;
      push(32'h1000D, 8'h2D);
      @(negedge clk) wr_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("st_gate%0d_wgo", k), host_wgo, 1'b0);
         check($sformatf("st_gate%0d_empty", k), wr_empty, 1'b0);
         @(negedge clk);
      end
      host_init = 1'b1;
      found = 1'b0;
      waited = 0;
      while (!found && waited < 10) begin
         @(negedge clk) #1;
         waited++;
         if (host_wgo) found = 1'b1;
      end
      check("st_wgo_seen", found, 1'b1);
      check("st_wgo_lat", waited, 2);
      check("st_we", host_we, 1'b1);
      check("st_cpu", cpu_addr, 64'h34);
      check("st_data", host_data_bus_write_out, dat(8'h2D));
      @(negedge clk) #1;
      check("st_post_empty", wr_empty, 1'b1);
      check("st_post_wgo", host_wgo, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
